calc_core: RTL and testbench
============================

Name: calc_core

Overview:
Arithmetic and entry engine of the calculator, directly upstream of the 7-segment display driver. Consumes single-cycle key events from the debounced keypad and builds decimal operands. Executes add, subtract, multiply and divide. Drives the unsigned 14-bit value (0..9999) that the display driver renders, plus error and busy flags.

Parameters:
WIDTH, 14, width of operands, result and to_display_nr.
MAX_VALUE, 9999, largest representable result; anything above is overflow.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe; key_code is valid in this cycle
key_code  input  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
to_display_nr  output  WIDTH  value shown by the display driver
error  output  1  high while in ERROR state
busy  output  1  high while a computation is in progress

Behaviour:
- Reset: state ENTRY_A; A, B, op, to_display_nr = 0; error = 0; busy = 0. Reset is asynchronous, so assertion during COMPUTE aborts immediately.
- Clear key (15) in any state, including COMPUTE: same values as reset, applied on the next clock edge (synchronous).
- States:
  - ENTRY_A, ENTRY_B, COMPUTE, RESULT, ERROR.
- Digit d in ENTRY_A or ENTRY_B:
  - acc <= acc*10 + d, only if the new value is <= MAX_VALUE; otherwise the digit is dropped.
  - to_display_nr follows acc in the same update cycle.
- Operator key:
  - ENTRY_A: latch op, go to ENTRY_B with B = 0 and b_started = 0. Display keeps showing A until the first B digit.
  - ENTRY_B: replace op; no chaining.
- Equals key:
  - ENTRY_B: go to COMPUTE.
  - ENTRY_A and RESULT: ignored.
- COMPUTE timing (equals sampled at edge t):
  - add/sub: busy high for one cycle (t+1); result visible from t+2.
  - mul/div: busy high for exactly WIDTH cycles (t+1..t+WIDTH); result visible from t+WIDTH+1.
  - While busy, all keys except clear are ignored.
- Arithmetic:
  - Products use a 2*WIDTH-bit intermediate.
  - Division is unsigned integer (truncating).
  - Result > MAX_VALUE, subtraction result < 0, or divide by zero: go to ERROR.
- RESULT:
  - to_display_nr = result and A = result.
  - Digit: start a new A, A = d.
  - Operator: chain, using A = result, and go to ENTRY_B.
- ERROR: error = 1 and to_display_nr = 0. Only clear or reset leaves this state.
- Simultaneity: key_valid arriving on the same cycle COMPUTE finishes is ignored, unless it is clear.

Decomposition:
- calc_pkg:
  - key code localparams KEY_ADD..KEY_CLEAR.
  - op_t enum {OP_ADD, OP_SUB, OP_MUL, OP_DIV}.
  - state_t enum for the five states.
  - MAX_VALUE default.
- Sub-module calc_muldiv: sequential shift-add multiplier and restoring divider.
  - Interface: start/op/a/b in; done/result/overflow/div_zero out.
  - Fixed WIDTH-cycle latency.
- calc_core holds the FSM and operand entry.

Test Plan:
1. Reset, then keys 5,4,2,3 -> to_display_nr = 5423, error = 0. A further digit 1 -> still 5423.
2. Keys 1,2,+,3,4,= -> display 12 until the first B digit, then 34; busy high exactly 1 cycle; display 46.
3. Keys 1,2,3,*,8,1,= -> busy high exactly 14 cycles; display 9963. Then *,2,= -> error = 1 and display 0. Clear -> error = 0 and display 0.
4. Keys 9,9,9,9,/,7,= -> 1428. Clear, then 5,/,0,= -> error = 1.
5. Keys 3,-,8,= -> error = 1. Keys 8,-,8,= -> display 0 with error = 0.
6. Clear key 5 cycles into a multiply -> next cycle busy = 0 and display 0. Async reset pulse mid-multiply -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator core.
//   - key code constants for the keypad event stream
//   - op_t (arithmetic operator) and state_t (entry/compute FSM states)
//   - default operand width and largest representable value
package calc_pkg;

   localparam int unsigned DefaultWidth    = 14;
   localparam int unsigned DefaultMaxValue = 9999;

   // Key codes 0..9 are digits.
   localparam logic [3:0] KEY_ADD    = 4'd10;
   localparam logic [3:0] KEY_SUB    = 4'd11;
   localparam logic [3:0] KEY_MUL    = 4'd12;
   localparam logic [3:0] KEY_DIV    = 4'd13;
   localparam logic [3:0] KEY_EQUALS = 4'd14;
   localparam logic [3:0] KEY_CLEAR  = 4'd15;

   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_DIV
   } op_t;

   typedef enum logic [2:0] {
      StEntryA,
      StEntryB,
      StCompute,
      StResult,
      StError
   } state_t;

   // Operator keys are contiguous, so the offset from KEY_ADD is the op_t encoding.
   function automatic op_t key_to_op(input logic [3:0] key);
      logic [3:0] idx;
      idx = key - KEY_ADD;
      return op_t'(idx[1:0]);
   endfunction

endpackage

// File: rtl/calc_muldiv.sv
// calc_muldiv: sequential shift-add multiplier and restoring divider.
// Both datapaths step together; op selects which one is reported. Latency is fixed at
// WIDTH clock edges after the start edge: done_o is high in the cycle before the final
// step, and result_o/overflow_o then carry the value that final step produces, so the
// consumer can register them on the same edge the iteration completes.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start_i      load operands and begin (ignored while abort_i)
//   abort_i      stop any running operation
//   op_i         OP_MUL or OP_DIV
//   a_i, b_i     multiplicand/dividend, multiplier/divisor
//   done_o       final step happens on the coming edge
//   result_o     product (low WIDTH bits) or quotient
//   overflow_o   product exceeds MAX_VALUE
//   div_zero_o   division with a zero divisor
module calc_muldiv
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter int unsigned MAX_VALUE = DefaultMaxValue
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             abort_i,
   input  op_t              op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             overflow_o,
   output logic             div_zero_o
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   logic            run_q;
   logic [CW-1:0]   cnt_q;
   logic            is_div_q;
   logic            dz_q;
   logic [W2-1:0]   mcand_q;
   logic [W2-1:0]   prod_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvsr_q;

   logic [W2-1:0]    prod_d;
   logic [WIDTH:0]   rem_sh;
   logic             fits;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   always_comb begin
      prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
      // Restoring step: bring in next dividend bit, subtract divisor if it fits.
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      fits   = (rem_sh >= {1'b0, dvsr_q});
      rem_d  = fits ? (rem_sh[WIDTH-1:0] - dvsr_q) : rem_sh[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], fits};
   end

   assign done_o     = run_q && (cnt_q == LastCnt);
   assign result_o   = is_div_q ? quo_d : prod_d[WIDTH-1:0];
   assign overflow_o = !is_div_q && (prod_d > W2'(MAX_VALUE));
   assign div_zero_o = is_div_q && dz_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
      end else if (abort_i) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start_i) begin
         run_q    <= 1'b1;
         cnt_q    <= '0;
         is_div_q <= (op_i == OP_DIV);
         dz_q     <= (b_i == '0);
         mcand_q  <= W2'(a_i);
         prod_q   <= '0;
         mplier_q <= b_i;
         rem_q    <= '0;
         quo_q    <= a_i;
         dvsr_q   <= b_i;
      end else if (run_q) begin
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_q + 1'b1;
         if (cnt_q == LastCnt) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/calc_core.sv
// calc_core: keypad-driven decimal entry and arithmetic engine feeding the display driver.
// Builds operands A and B from digit keys, runs add/sub in one busy cycle and mul/div
// through calc_muldiv in WIDTH busy cycles, and reports overflow, negative results and
// divide-by-zero through the ERROR state.
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   key_valid      one-cycle key strobe
//   key_code       0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
//   to_display_nr  value for the 7-segment driver (0 in ERROR)
//   error          high while in ERROR
//   busy           high while a computation is in progress
module calc_core
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter int unsigned MAX_VALUE = DefaultMaxValue
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic [WIDTH-1:0] to_display_nr,
   output logic             error,
   output logic             busy
);

   // Digit append needs headroom for acc*10+9 before the range check.
   localparam int unsigned AW = WIDTH + 4;
   localparam int unsigned SW = WIDTH + 1;

   state_t           state_q;
   op_t              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             b_started_q;
   logic [WIDTH-1:0] disp_q;
   logic             error_q;
   logic             busy_q;

   logic             is_digit;
   logic             is_op;
   logic             is_eq;
   logic             is_clr;
   op_t              key_op;
   logic [WIDTH-1:0] entry_base;
   logic [AW-1:0]    entry_app;
   logic             entry_ok;
   logic [SW-1:0]    sum_w;
   logic             fin;
   logic             fin_err;
   logic [WIDTH-1:0] fin_val;

   logic             md_start;
   logic             md_done;
   logic [WIDTH-1:0] md_result;
   logic             md_overflow;
   logic             md_div_zero;

   always_comb begin
      is_digit = key_valid && (key_code <= 4'd9);
      is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
      is_eq    = key_valid && (key_code == KEY_EQUALS);
      is_clr   = key_valid && (key_code == KEY_CLEAR);
      key_op   = key_to_op(key_code);

      // B starts from zero on its first digit regardless of the held register.
      if (state_q == StEntryB) begin
         entry_base = b_started_q ? b_q : '0;
      end else begin
         entry_base = a_q;
      end
      entry_app = AW'(entry_base) * AW'(10) + AW'(key_code);
      entry_ok  = (entry_app <= AW'(MAX_VALUE));

      sum_w    = SW'(a_q) + SW'(b_q);
      md_start = (state_q == StEntryB) && is_eq && ((op_q == OP_MUL) || (op_q == OP_DIV));

      fin     = 1'b0;
      fin_err = 1'b0;
      fin_val = '0;
      if (state_q == StCompute) begin
         unique case (op_q)
            OP_ADD: begin
               fin     = 1'b1;
               fin_err = (sum_w > SW'(MAX_VALUE));
               fin_val = sum_w[WIDTH-1:0];
            end
            OP_SUB: begin
               fin     = 1'b1;
               fin_err = (a_q < b_q);
               fin_val = a_q - b_q;
            end
            OP_MUL, OP_DIV: begin
               fin     = md_done;
               fin_err = md_overflow || md_div_zero;
               fin_val = md_result;
            end
            default: ;
         endcase
      end
   end

   calc_muldiv #(
      .WIDTH     (WIDTH),
      .MAX_VALUE (MAX_VALUE)
   ) u_muldiv (
      .clk        (clk),
      .reset      (reset),
      .start_i    (md_start),
      .abort_i    (is_clr),
      .op_i       (op_q),
      .a_i        (a_q),
      .b_i        (b_q),
      .done_o     (md_done),
      .result_o   (md_result),
      .overflow_o (md_overflow),
      .div_zero_o (md_div_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StEntryA;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         b_started_q <= 1'b0;
         disp_q      <= '0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else if (is_clr) begin
         state_q     <= StEntryA;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         b_started_q <= 1'b0;
         disp_q      <= '0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StEntryA: begin
               if (is_digit) begin
                  if (entry_ok) begin
                     a_q    <= entry_app[WIDTH-1:0];
                     disp_q <= entry_app[WIDTH-1:0];
                  end
               end else if (is_op) begin
                  op_q        <= key_op;
                  b_q         <= '0;
                  b_started_q <= 1'b0;
                  state_q     <= StEntryB;
               end
            end
            StEntryB: begin
               if (is_digit) begin
                  if (entry_ok) begin
                     b_q         <= entry_app[WIDTH-1:0];
                     disp_q      <= entry_app[WIDTH-1:0];
                     b_started_q <= 1'b1;
                  end
               end else if (is_op) begin
                  op_q <= key_op;
               end else if (is_eq) begin
                  state_q <= StCompute;
                  busy_q  <= 1'b1;
               end
            end
            StCompute: begin
               // Non-clear keys are ignored here, including on the finishing cycle.
               if (fin) begin
                  busy_q <= 1'b0;
                  if (fin_err) begin
                     state_q <= StError;
                     error_q <= 1'b1;
                     disp_q  <= '0;
                  end else begin
                     state_q <= StResult;
                     a_q     <= fin_val;
                     disp_q  <= fin_val;
                  end
               end
            end
            StResult: begin
               if (is_digit) begin
                  a_q     <= WIDTH'(key_code);
                  disp_q  <= WIDTH'(key_code);
                  state_q <= StEntryA;
               end else if (is_op) begin
                  op_q        <= key_op;
                  b_q         <= '0;
                  b_started_q <= 1'b0;
                  state_q     <= StEntryB;
               end
            end
            StError: ;
            default: begin
               state_q <= StEntryA;
            end
         endcase
      end
   end

   assign to_display_nr = disp_q;
   assign error         = error_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_calc_core.sv
module tb_calc_core;

   localparam int unsigned WIDTH = 14;
   localparam int MaxVal = 9999;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             key_valid = 1'b0;
   logic [3:0]       key_code = 4'd0;
   logic [WIDTH-1:0] to_display_nr;
   logic             error;
   logic             busy;

   int errors = 0;
   int checks = 0;

   calc_core #(
      .WIDTH     (WIDTH),
      .MAX_VALUE (MaxVal)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .to_display_nr (to_display_nr),
      .error         (error),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // One key strobe, sampled on the posedge between the two falling edges.
   task automatic press(input int k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'(k);
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic enter_num(input int n);
      int digs[$];
      int v;
      v = n;
      if (v == 0) digs.push_back(0);
      while (v > 0) begin
         digs.push_front(v % 10);
         v = v / 10;
      end
      foreach (digs[i]) press(digs[i]);
   endtask

   // Counts falling edges with busy high, bounded.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (to_display_nr !== 14'd0) begin
         errors++; $display("FAIL reset_display: got %0d expected 0", to_display_nr);
      end
      checks++;
      if (error !== 1'b0) begin
         errors++; $display("FAIL reset_error: got %b expected 0", error);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_entry;
      press(15);
      enter_num(5423);
      checks++;
      if (to_display_nr !== 14'd5423 || error !== 1'b0) begin
         errors++; $display("FAIL entry_5423: got %0d err %b expected 5423 err 0", to_display_nr, error);
      end
      press(1);
      checks++;
      if (to_display_nr !== 14'd5423) begin
         errors++; $display("FAIL entry_drop: got %0d expected 5423", to_display_nr);
      end
   endtask

   task automatic test_add;
      int n;
      press(15);
      enter_num(12);
      press(10);
      checks++;
      if (to_display_nr !== 14'd12) begin
         errors++; $display("FAIL add_hold_a: got %0d expected 12", to_display_nr);
      end
      press(3);
      checks++;
      if (to_display_nr !== 14'd3) begin
         errors++; $display("FAIL add_first_b: got %0d expected 3", to_display_nr);
      end
      press(4);
      checks++;
      if (to_display_nr !== 14'd34) begin
         errors++; $display("FAIL add_b: got %0d expected 34", to_display_nr);
      end
      press(14);
      wait_busy(n);
      checks++;
      if (n != 1) begin
         errors++; $display("FAIL add_busy_cycles: got %0d expected 1", n);
      end
      checks++;
      if (to_display_nr !== 14'd46 || error !== 1'b0) begin
         errors++; $display("FAIL add_result: got %0d err %b expected 46 err 0", to_display_nr, error);
      end
   endtask

   task automatic test_mul_overflow;
      int n;
      press(15);
      enter_num(123); press(12); enter_num(81); press(14);
      wait_busy(n);
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL mul_busy_cycles: got %0d expected 14", n);
      end
      checks++;
      if (to_display_nr !== 14'd9963) begin
         errors++; $display("FAIL mul_result: got %0d expected 9963", to_display_nr);
      end
      press(12); press(2); press(14);
      wait_busy(n);
      checks++;
      if (error !== 1'b1 || to_display_nr !== 14'd0) begin
         errors++; $display("FAIL mul_overflow: got %0d err %b expected 0 err 1", to_display_nr, error);
      end
      press(3);
      checks++;
      if (error !== 1'b1 || to_display_nr !== 14'd0) begin
         errors++; $display("FAIL error_sticky: got %0d err %b expected 0 err 1", to_display_nr, error);
      end
      press(15);
      checks++;
      if (error !== 1'b0 || to_display_nr !== 14'd0) begin
         errors++; $display("FAIL clear_error: got %0d err %b expected 0 err 0", to_display_nr, error);
      end
   endtask

   task automatic test_div;
      int n;
      press(15);
      enter_num(9999); press(13); enter_num(7); press(14);
      wait_busy(n);
      checks++;
      if (n != 14) begin
         errors++; $display("FAIL div_busy_cycles: got %0d expected 14", n);
      end
      checks++;
      if (to_display_nr !== 14'd1428 || error !== 1'b0) begin
         errors++; $display("FAIL div_result: got %0d err %b expected 1428 err 0", to_display_nr, error);
      end
      press(15);
      press(5); press(13); press(0); press(14);
      wait_busy(n);
      checks++;
      if (error !== 1'b1 || to_display_nr !== 14'd0) begin
         errors++; $display("FAIL div_zero: got %0d err %b expected 0 err 1", to_display_nr, error);
      end
   endtask

   task automatic test_sub;
      int n;
      press(15);
      press(3); press(11); press(8); press(14);
      wait_busy(n);
      checks++;
      if (error !== 1'b1 || to_display_nr !== 14'd0) begin
         errors++; $display("FAIL sub_negative: got %0d err %b expected 0 err 1", to_display_nr, error);
      end
      press(15);
      press(8); press(11); press(8); press(14);
      wait_busy(n);
      checks++;
      if (error !== 1'b0 || to_display_nr !== 14'd0 || n != 1) begin
         errors++; $display("FAIL sub_zero: got %0d err %b busy %0d expected 0 err 0 busy 1",
                            to_display_nr, error, n);
      end
   endtask

   task automatic test_ignored_keys;
      int n;
      press(15);
      press(7); press(14);
      checks++;
      if (to_display_nr !== 14'd7 || busy !== 1'b0) begin
         errors++; $display("FAIL eq_in_entry_a: got %0d busy %b expected 7 busy 0", to_display_nr, busy);
      end
      press(15);
      press(2); press(12); press(3); press(14);
      press(9); press(10);
      wait_busy(n);
      checks++;
      if (to_display_nr !== 14'd6 || error !== 1'b0) begin
         errors++; $display("FAIL keys_while_busy: got %0d err %b expected 6 err 0", to_display_nr, error);
      end
      press(14);
      checks++;
      if (to_display_nr !== 14'd6 || busy !== 1'b0) begin
         errors++; $display("FAIL eq_in_result: got %0d busy %b expected 6 busy 0", to_display_nr, busy);
      end
      press(4);
      press(10); press(1); press(14);
      wait_busy(n);
      checks++;
      if (to_display_nr !== 14'd5) begin
         errors++; $display("FAIL result_new_a: got %0d expected 5", to_display_nr);
      end
   endtask

   task automatic test_abort;
      int n;
      press(15);
      enter_num(123); press(12); enter_num(81); press(14);
      repeat (4) @(negedge clk);
      press(15);
      checks++;
      if (busy !== 1'b0 || to_display_nr !== 14'd0 || error !== 1'b0) begin
         errors++; $display("FAIL clear_mid_mul: got %0d busy %b err %b expected 0 busy 0 err 0",
                            to_display_nr, busy, error);
      end
      // A fresh multiply after the abort must still be correct.
      press(6); press(12); press(7); press(14);
      wait_busy(n);
      checks++;
      if (to_display_nr !== 14'd42 || n != 14) begin
         errors++; $display("FAIL mul_after_abort: got %0d busy %0d expected 42 busy 14", to_display_nr, n);
      end
      press(15);
      enter_num(123); press(12); enter_num(81); press(14);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || to_display_nr !== 14'd0) begin
         errors++; $display("FAIL async_reset: got %0d busy %b expected 0 busy 0", to_display_nr, busy);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random_entry;
      for (int it = 0; it < 10; it++) begin
         int acc;
         int len;
         int d;
         press(15);
         acc = 0;
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) begin
            d = $urandom_range(0, 9);
            press(d);
            if (acc * 10 + d <= MaxVal) acc = acc * 10 + d;
         end
         checks++;
         if (to_display_nr !== 14'(acc)) begin
            errors++; $display("FAIL rand_entry[%0d]: got %0d expected %0d", it, to_display_nr, acc);
         end
      end
   endtask

   task automatic test_random_ops;
      int res;
      bit have_res;
      have_res = 1'b0;
      res = 0;
      for (int it = 0; it < 40; it++) begin
         int a;
         int b;
         int opk;
         int exp;
         int n;
         int exp_n;
         bit exp_err;
         opk = $urandom_range(10, 13);
         if (have_res && $urandom_range(0, 1) == 1) begin
            a = res;
         end else begin
            press(15);
            a = (opk == 12) ? $urandom_range(0, 200) : $urandom_range(0, MaxVal);
            enter_num(a);
         end
         case (opk)
            12:      b = $urandom_range(0, 200);
            13:      b = $urandom_range(0, 20);
            default: b = $urandom_range(0, MaxVal);
         endcase
         press(opk);
         enter_num(b);
         press(14);
         wait_busy(n);
         exp_err = 1'b0;
         case (opk)
            10: exp = a + b;
            11: exp = a - b;
            12: exp = a * b;
            default: begin
               if (b == 0) begin
                  exp_err = 1'b1;
                  exp = 0;
               end else begin
                  exp = a / b;
               end
            end
         endcase
         if (exp < 0 || exp > MaxVal) exp_err = 1'b1;
         if (exp_err) exp = 0;
         exp_n = (opk >= 12) ? 14 : 1;
         checks++;
         if (n != exp_n || error !== exp_err || to_display_nr !== 14'(exp)) begin
            errors++;
            $display("FAIL rand_op[%0d] %0d key%0d %0d: got %0d err %b busy %0d expected %0d err %b busy %0d",
                     it, a, opk, b, to_display_nr, error, n, exp, exp_err, exp_n);
         end
         have_res = !exp_err;
         res = exp;
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_add();
      test_mul_overflow();
      test_div();
      test_sub();
      test_ignored_keys();
      test_abort();
      test_random_entry();
      test_random_ops();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
